add32_seq_ctrl: RTL and testbench

ADD32_SEQ_CTRL -- requirements
Module: add32_seq_ctrl

---
 rtl/add32_seq_pkg.sv | 19 +
 rtl/RCA_8_bit.sv | 30 +++
 rtl/add32_seq_ctrl.sv | 116 +++++++++++
 tb/tb_add32_seq_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/add32_seq_pkg.sv
// ---------------------------------------------------------------------------
// add32_seq_pkg : shared FSM state type and slice width for add32_seq_ctrl
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package add32_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/RCA_8_bit.sv
// ---------------------------------------------------------------------------
// RCA_8_bit : 8-bit ripple-carry adder built from full-adder cells
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module RCA_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] s,
  output logic       c_out
);

  logic [8:0] c;

  assign c[0] = c_in;

  generate
    for (genvar k = 0; k < 8; k++) begin : g_bit
      assign s[k]   = a[k] ^ b[k] ^ c[k];
      assign c[k+1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
    end
  endgenerate

  assign c_out = c[8];

endmodule

`default_nettype wire

// File: rtl/add32_seq_ctrl.sv
// ---------------------------------------------------------------------------
// add32_seq_ctrl : slice-serial W-bit adder (one 8-bit slice per RUN cycle);
//                  define ADD_SUB_EN to enable subtraction through the sub port
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module add32_seq_ctrl
  import add32_seq_pkg::*;
#(
  parameter  int NSLICE = 4,
  localparam int W      = SLICE_W * NSLICE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         c_out,
  output logic         ovf
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [W-1:0]         a_r;
  logic [W-1:0]         b_r;
  logic                 sub_r;
  logic                 carry;
  logic                 sub_eff;
  logic [SLICE_W-1:0]   slice_a;
  logic [SLICE_W-1:0]   slice_b;
  logic [SLICE_W-1:0]   slice_s;
  logic                 slice_c;
  logic                 last_slice;

`ifdef ADD_SUB_EN
  assign sub_eff = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff    = 1'b0;
`endif

  // Subtraction is a + ~b + 1, so the inversion is applied slice by slice.
  assign slice_a    = a_r[int'(idx)*SLICE_W +: SLICE_W];
  assign slice_b    = b_r[int'(idx)*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_r}};
  assign last_slice = (idx == IW'(NSLICE - 1));

  RCA_8_bit u_rca (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry),
    .s     (slice_s),
    .c_out (slice_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub_eff;
            carry <= sub_eff | c_in;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s[int'(idx)*SLICE_W +: SLICE_W] <= slice_s;
          carry <= slice_c;
          if (last_slice) begin
            c_out <= slice_c;
            ovf   <= (a_r[W-1] == (b_r[W-1] ^ sub_r)) && (slice_s[SLICE_W-1] != a_r[W-1]);
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // The done pulse is registered here so it lands in the following cycle.
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_add32_seq_ctrl.sv
// Self-checking bench for add32_seq_ctrl (NSLICE=4): directed cases plus random
// operations compared against a plain-arithmetic reference model.
`default_nettype none

module tb_add32_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c_out;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  add32_seq_ctrl #(.NSLICE(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c_out (c_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: s/c_out = (a + Beff + cin) mod 2^W with its carry; ovf from signs.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                       input logic msub, output logic [W-1:0] es, output logic ec,
                       output logic eo);
    logic [W:0]   sum;
    logic [W-1:0] beff;
    logic         cin;
    beff = mb;
    cin  = mcin;
`ifdef ADD_SUB_EN
    if (msub) begin
      beff = ~mb;
      cin  = 1'b1;
    end
`endif
    sum = {1'b0, ma} + {1'b0, beff} + {{W{1'b0}}, cin};
    es  = sum[W-1:0];
    ec  = sum[W];
    eo  = (ma[W-1] == beff[W-1]) && (es[W-1] != ma[W-1]);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic isub);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           lat;
    model(ia, ib, icin, isub, es, ec, eo);
    a = ia; b = ib; c_in = icin; sub = isub; start = 1'b1;
    step();
    start = 1'b0;
    check_val({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (done) begin
        lat = k;
        break;
      end
    end
    check_val({tag, "_latency"}, 64'(lat), 64'd5);
    check_val({tag, "_s"}, 64'(s), 64'(es));
    check_val({tag, "_c_out"}, 64'(c_out), 64'(ec));
    check_val({tag, "_ovf"}, 64'(ovf), 64'(eo));
    check_val({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    step();
    check_val({tag, "_done_width"}, 64'(done), 64'd0);
    check_val({tag, "_s_hold"}, 64'(s), 64'(es));
  endtask

  initial begin
    logic         seen;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_s", 64'(s), 64'd0);
    check_val("rst_cout", 64'(c_out), 64'd0);
    check_val("rst_ovf", 64'(ovf), 64'd0);
    step();

    run_op("case1", 32'h0000_006D, 32'h0000_0066, 1'b0, 1'b0);
    run_op("case2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    run_op("case3", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op("case4", 32'd5, 32'd7, 1'b0, 1'b1);
    run_op("sub_eq", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);

    // Abort in the second RUN cycle, with a stray start pulse in the first.
    a = 32'h1234_5678; b = 32'h0F0F_0F0F; c_in = 1'b1; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b1;
    a = 32'hDEAD_BEEF;
    step();
    start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    check_val("abort_s", 64'(s), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done) seen = 1'b1;
    end
    check_val("abort_no_done", 64'(seen), 64'd0);
    run_op("after_abort", 32'h0000_006D, 32'h0000_0066, 1'b0, 1'b0);

    // Start held high: done pulses must come at edges 5 and 11 after first accept.
    model(32'h89AB_CDEF, 32'h7654_3210, 1'b1, 1'b0, es, ec, eo);
    a = 32'h89AB_CDEF; b = 32'h7654_3210; c_in = 1'b1; sub = 1'b0; start = 1'b1;
    step();
    for (int k = 1; k <= 11; k++) begin
      step();
      check_val($sformatf("hold_done_k%0d", k), 64'(done), 64'((k == 5) || (k == 11)));
    end
    start = 1'b0;
    check_val("hold_s", 64'(s), 64'(es));
    check_val("hold_cout", 64'(c_out), 64'(ec));
    step();
    check_val("hold_done_end", 64'(done), 64'd0);
    step();

    for (int n = 0; n < 24; n++) begin
      run_op($sformatf("rnd%0d", n), W'($urandom), W'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
